// File: rtl/status_flags.sv
// Processor status (P) register stage behind the ALU: aligns per-op flag-update
// intent with the ALU's registered outputs, and handles flag ops, P loads and the push image.
module status_flags #(
    parameter logic [7:0] RESET_P = 8'h34
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_valid,
    input  logic [4:0] alu_op,
    input  logic [3:0] upd_mask,
    input  logic [7:0] alu_operand,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic [2:0] flag_op,
    input  logic       p_load,
    input  logic [7:0] p_in,
    input  logic       brk,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       carry_out,
    output logic       irq_mask,
    output logic       upd_pending
);

    localparam logic [4:0] OP_SHR = 5'd7;
    localparam logic [4:0] OP_SHL = 5'd8;
    localparam logic [4:0] OP_RTR = 5'd9;
    localparam logic [4:0] OP_RTL = 5'd10;

    // Bit positions inside upd_mask, ordered {N,Z,C,V}
    localparam int M_N = 3;
    localparam int M_Z = 2;
    localparam int M_C = 1;
    localparam int M_V = 0;

    typedef enum logic [2:0] {
        FL_NONE = 3'd0,
        FL_CLC  = 3'd1,
        FL_SEC  = 3'd2,
        FL_CLI  = 3'd3,
        FL_SEI  = 3'd4,
        FL_CLD  = 3'd5,
        FL_SED  = 3'd6,
        FL_CLV  = 3'd7
    } flag_op_e;

    logic       r_n, r_v, r_d, r_i, r_z, r_c;
    logic       r_pend_valid;
    logic [4:0] r_pend_op;
    logic [3:0] r_pend_mask;
    logic [7:0] r_pend_opnd;

    logic       w_commit_c;
    logic       w_n_nxt, w_v_nxt, w_d_nxt, w_i_nxt, w_z_nxt, w_c_nxt;
    logic       w_unused;

    // Bits 5 and 4 of a loaded byte have no storage behind them.
    assign w_unused = &{1'b0, p_in[5:4]};

    // Shifts and rotates take their carry from the operand captured at issue.
    always_comb begin
        unique case (r_pend_op)
            OP_SHL, OP_RTL: w_commit_c = r_pend_opnd[7];
            OP_SHR, OP_RTR: w_commit_c = r_pend_opnd[0];
            default:        w_commit_c = alu_carry;
        endcase
    end

    // Writers applied lowest priority first: flag_op, then ALU commit, then p_load.
    always_comb begin
        // NOTE: every next-state value defaults to the held flag first, so no path infers a latch.
        w_n_nxt = r_n;
        w_v_nxt = r_v;
        w_d_nxt = r_d;
        w_i_nxt = r_i;
        w_z_nxt = r_z;
        w_c_nxt = r_c;

        case (flag_op_e'(flag_op))
            FL_CLC:  w_c_nxt = 1'b0;
            FL_SEC:  w_c_nxt = 1'b1;
            FL_CLI:  w_i_nxt = 1'b0;
            FL_SEI:  w_i_nxt = 1'b1;
            FL_CLD:  w_d_nxt = 1'b0;
            FL_SED:  w_d_nxt = 1'b1;
            FL_CLV:  w_v_nxt = 1'b0;
            default: ;
        endcase

        if (r_pend_valid) begin
            if (r_pend_mask[M_N]) w_n_nxt = alu_result[7];
            if (r_pend_mask[M_Z]) w_z_nxt = (alu_result == 8'd0);
            if (r_pend_mask[M_C]) w_c_nxt = w_commit_c;
            if (r_pend_mask[M_V]) w_v_nxt = alu_overflow;
        end

        if (p_load) begin
            w_n_nxt = p_in[7];
            w_v_nxt = p_in[6];
            w_d_nxt = p_in[3];
            w_i_nxt = p_in[2];
            w_z_nxt = p_in[1];
            w_c_nxt = p_in[0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n          <= RESET_P[7];
            r_v          <= RESET_P[6];
            r_d          <= RESET_P[3];
            r_i          <= RESET_P[2];
            r_z          <= RESET_P[1];
            r_c          <= RESET_P[0];
            r_pend_valid <= 1'b0;
            r_pend_op    <= '0;
            r_pend_mask  <= '0;
            r_pend_opnd  <= '0;
        end else begin
            r_n          <= w_n_nxt;
            r_v          <= w_v_nxt;
            r_d          <= w_d_nxt;
            r_i          <= w_i_nxt;
            r_z          <= w_z_nxt;
            r_c          <= w_c_nxt;
            r_pend_valid <= alu_valid;
            r_pend_op    <= alu_op;
            r_pend_mask  <= upd_mask;
            r_pend_opnd  <= alu_operand;
        end
    end

    // Forward the carry about to be committed so a dependent op issued now sees it.
    assign carry_out   = (r_pend_valid && r_pend_mask[M_C]) ? w_commit_c : r_c;
    assign p_out       = {r_n, r_v, 1'b1, 1'b1, r_d, r_i, r_z, r_c};
    assign p_push      = {r_n, r_v, 1'b1, brk,  r_d, r_i, r_z, r_c};
    assign irq_mask    = r_i;
    assign upd_pending = r_pend_valid;

endmodule

// File: tb/tb_status_flags.sv
// Self-checking bench for status_flags: directed test-plan cases plus randomized
// traffic compared every cycle against a byte-level reference model.
module tb_status_flags;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alu_valid = 1'b0;
    logic [4:0] alu_op = '0;
    logic [3:0] upd_mask = '0;
    logic [7:0] alu_operand = '0;
    logic [7:0] alu_result = '0;
    logic       alu_carry = 1'b0;
    logic       alu_overflow = 1'b0;
    logic [2:0] flag_op = '0;
    logic       p_load = 1'b0;
    logic [7:0] p_in = '0;
    logic       brk = 1'b0;
    logic [7:0] p_out;
    logic [7:0] p_push;
    logic       carry_out;
    logic       irq_mask;
    logic       upd_pending;

    always #5 clk = ~clk;

    status_flags #(.RESET_P(8'h34)) dut (
        .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_op(alu_op),
        .upd_mask(upd_mask), .alu_operand(alu_operand), .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .flag_op(flag_op),
        .p_load(p_load), .p_in(p_in), .brk(brk), .p_out(p_out), .p_push(p_push),
        .carry_out(carry_out), .irq_mask(irq_mask), .upd_pending(upd_pending)
    );

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: P held as a byte in its architectural layout.
    typedef struct {
        bit       valid;
        bit [4:0] op;
        bit [3:0] mask;
        bit [7:0] opnd;
    } pend_t;

    bit [7:0] m_p;
    pend_t    m_pend;

    // Flag values an ALU result produces, placed at their P bit positions.
    function automatic bit [7:0] flag_image(input bit [4:0] op, input bit [7:0] opnd,
                                            input bit [7:0] res, input bit cy, input bit ov);
        bit c;
        c = cy;
        if (op == 5'd8 || op == 5'd10) c = opnd[7];
        else if (op == 5'd7 || op == 5'd9) c = opnd[0];
        return {res[7], ov, 4'b0000, (res == 8'd0), c};
    endfunction

    // {N,Z,C,V} enables mapped onto P bit positions.
    function automatic bit [7:0] mask_bits(input bit [3:0] m);
        return {m[3], m[0], 4'b0000, m[2], m[1]};
    endfunction

    always @(posedge clk or posedge reset) begin
        bit [7:0] nx;
        bit [7:0] wm;
        if (reset) begin
            m_p    = 8'h34;
            m_pend = '{default: 0};
        end else begin
            nx = m_p;
            case (flag_op)
                3'd1: nx[0] = 1'b0;
                3'd2: nx[0] = 1'b1;
                3'd3: nx[2] = 1'b0;
                3'd4: nx[2] = 1'b1;
                3'd5: nx[3] = 1'b0;
                3'd6: nx[3] = 1'b1;
                3'd7: nx[6] = 1'b0;
                default: ;
            endcase
            if (m_pend.valid) begin
                wm = mask_bits(m_pend.mask);
                nx = (nx & ~wm) |
                     (flag_image(m_pend.op, m_pend.opnd, alu_result, alu_carry, alu_overflow) & wm);
            end
            if (p_load) nx = (p_in & 8'hCF) | 8'h30;
            m_p    = nx;
            m_pend = '{alu_valid, alu_op, upd_mask, alu_operand};
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit [7:0] img;
        bit       ec;
        if (en) begin
            ec = m_p[0];
            if (m_pend.valid && m_pend.mask[1]) begin
                img = flag_image(m_pend.op, m_pend.opnd, alu_result, alu_carry, alu_overflow);
                ec  = img[0];
            end
            check("p_out", p_out, m_p | 8'h30);
            check("p_push", p_push, (m_p & 8'hCF) | 8'h20 | {3'b000, brk, 4'b0000});
            check("carry_out", 8'(carry_out), 8'(ec));
            check("irq_mask", 8'(irq_mask), 8'(m_p[2]));
            check("upd_pending", 8'(upd_pending), 8'(m_pend.valid));
        end
    end

    task automatic idle();
        alu_valid   = 1'b0;
        alu_op      = '0;
        upd_mask    = '0;
        alu_operand = '0;
        flag_op     = '0;
        p_load      = 1'b0;
        p_in        = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [3:0] m, input logic [7:0] opnd);
        alu_valid   = 1'b1;
        alu_op      = op;
        upd_mask    = m;
        alu_operand = opnd;
    endtask

    bit [4:0] ops [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd12};

    initial begin
        #1 reset = 1'b1;
        idle();
        step();
        en = 1'b1;
        step();
        #2;
        check("rst_p_out", p_out, 8'h34);
        check("rst_push_brk0", p_push, 8'h24);
        check("rst_carry", 8'(carry_out), 8'h00);
        check("rst_pending", 8'(upd_pending), 8'h00);
        check("rst_irq", 8'(irq_mask), 8'h01);
        brk = 1'b1;
        #1;
        check("rst_push_brk1", p_push, 8'h34);
        brk = 1'b0;
        reset = 1'b0;
        step();

        // ADD, full mask, zero result with carry and overflow
        issue(5'd0, 4'b1111, 8'h10);
        step();
        idle();
        alu_result = 8'h00; alu_carry = 1'b1; alu_overflow = 1'b1;
        #2 check("add_pending", 8'(upd_pending), 8'h01);
        step();
        #2 check("add_p_out", p_out, 8'h77);
        check("add_pending_clr", 8'(upd_pending), 8'h00);

        // SHL of 8'h81 with {N,Z,C}: carry comes from operand bit 7
        issue(5'd8, 4'b1110, 8'h81);
        step();
        idle();
        alu_result = 8'h02; alu_carry = 1'b0; alu_overflow = 1'b0;
        #2 check("shl_carry_fwd", 8'(carry_out), 8'h01);
        step();
        #2 check("shl_p_out", p_out, 8'h75);

        // CLC, then SEC: carry_out follows one cycle later, no bypass
        flag_op = 3'd1;
        step();
        idle();
        #2 check("clc_carry", 8'(carry_out), 8'h00);
        flag_op = 3'd2;
        #1 check("sec_no_bypass", 8'(carry_out), 8'h00);
        step();
        idle();
        issue(5'd0, 4'b1111, 8'h01);
        #2 check("sec_carry", 8'(carry_out), 8'h01);
        step();
        issue(5'd0, 4'b1111, 8'h02);
        alu_result = 8'h40; alu_carry = 1'b0; alu_overflow = 1'b0;
        #2 check("fwd_carry0", 8'(carry_out), 8'h00);
        step();
        idle();
        alu_result = 8'h80; alu_carry = 1'b1; alu_overflow = 1'b0;
        #2 check("fwd_carry1", 8'(carry_out), 8'h01);
        step();
        #2 check("add2_p_out", p_out, 8'hB5);

        // Same edge: p_load beats the Z commit and SEI
        issue(5'd2, 4'b0100, 8'h00);
        step();
        idle();
        alu_result = 8'h00;
        p_load = 1'b1; p_in = 8'h00; flag_op = 3'd4;
        step();
        idle();
        #2 check("prio_p_out", p_out, 8'h30);
        check("prio_irq", 8'(irq_mask), 8'h00);

        // Reset during the result cycle discards the pending update
        issue(5'd0, 4'b1111, 8'hFF);
        step();
        idle();
        alu_result = 8'h00; alu_carry = 1'b1; alu_overflow = 1'b1;
        #1 reset = 1'b1;
        #1 check("midrst_pending", 8'(upd_pending), 8'h00);
        #1 reset = 1'b0;
        step();
        #2 check("midrst_p_out", p_out, 8'h34);
        check("midrst_pending_rel", 8'(upd_pending), 8'h00);

        // Randomized traffic checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
            alu_valid    = ($urandom_range(0, 2) != 0);
            alu_op       = ops[$urandom_range(0, 11)];
            upd_mask     = 4'($urandom);
            alu_operand  = 8'($urandom);
            alu_result   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            alu_carry    = 1'($urandom);
            alu_overflow = 1'($urandom);
            flag_op      = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            p_load       = ($urandom_range(0, 15) == 0);
            p_in         = 8'($urandom);
            brk          = 1'($urandom);
            reset        = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_flags.md
# status_flags

Processor status (P) register stage sitting directly downstream of the ALU. It captures per-operation flag-update intent in the cycle an ALU op is issued, and aligns it with the ALU's one-cycle registered outputs. On the following cycle it commits N, Z, C and V from the ALU result. It also handles explicit flag instructions (CLC/SEC/CLI/SEI/CLD/SED/CLV), whole-register loads (PLP/RTI) and the push image (PHP/BRK), and supplies the carry back into the ALU.

## Interface
Parameters:
- RESET_P, 8'h34, value of the P image after reset (N V 1 B D I Z C; I=1, B=1, others 0)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces all state to reset values
- alu_valid  in  1  ALU op issued this cycle; ALU outputs valid next cycle
- alu_op  in  5  ALU opcode issued this cycle (ADD 0, SUB 1, AND 2, OR 3, XOR 4, INC 5, DEC 6, SHR 7, SHL 8, RTR 9, RTL 10, LD 12)
- upd_mask  in  4  {N,Z,C,V} write enables for the issued op
- alu_operand  in  8  ALU operand1 at issue; used for shift/rotate carry-out
- alu_result  in  8  registered ALU result, one cycle after issue
- alu_carry  in  1  registered ALU carry, one cycle after issue
- alu_overflow  in  1  registered ALU overflow, one cycle after issue
- flag_op  in  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLD, 6 SED, 7 CLV
- p_load  in  1  load P from p_in (PLP/RTI)
- p_in  in  8  byte for p_load; bits 5 and 4 ignored
- brk  in  1  selects B=1 in p_push (BRK/PHP), 0 for IRQ/NMI push
- p_out  out  8  {N,V,1,1,D,I,Z,C}
- p_push  out  8  {N,V,1,brk,D,I,Z,C}, combinational
- carry_out  out  1  carry into ALU, forwarded (see Timing)
- irq_mask  out  1  current I flag
- upd_pending  out  1  a captured ALU flag update commits at the next edge

## Operation
- Stored flags: N, V, D, I, Z, C. Bits 5 and 4 are not stored.
- Issue stage: when alu_valid=1, capture pend_valid=1, pend_op=alu_op, pend_mask=upd_mask and pend_opnd=alu_operand. When alu_valid=0, pend_valid is cleared.
- Commit (pend_valid=1), using the values present this cycle:
  - N = alu_result[7]
  - Z = (alu_result == 0)
  - V = alu_overflow
  - C: SHL/RTL give pend_opnd[7]; SHR/RTR give pend_opnd[0]; all other ops give alu_carry.
- Each flag is written only if its pend_mask bit is set.
- flag_op writes its single flag at the edge it is presented.
- p_load writes N, V, D, I, Z, C from p_in bits 7, 6, 3, 2, 1, 0.
- Same-edge priority, per bit: p_load > pending ALU commit > flag_op. Writers to different bits all apply.
- D is stored and visible but never alters ALU behaviour, since the 2A03 has no decimal mode.

## Timing
- Reset (asynchronous): pend_valid=0 and P=RESET_P. Resulting outputs:
  - p_out=8'h34
  - irq_mask=1
  - carry_out=0
  - upd_pending=0
  - p_push=8'h24 | (brk<<4)
- Latency: op issued at edge-cycle T; ALU result at T+1; flags committed at the T+1 edge and visible on p_out at T+2.
- Back-to-back issue every cycle is supported. Commits happen in issue order, one per cycle, with no stall.
- carry_out = (pend_valid & pend_mask[C]) ? committed-C-value : C. This gives a dependent op issued at T+1 the carry produced by the op at T.
- flag_op and p_load changes take effect at the next edge. carry_out reflects SEC/CLC one cycle later, with no bypass.
- Reset asserted mid-operation discards the pending update. The ALU result arriving after reset release is ignored unless alu_valid was sampled high after release.
- An alu_valid with upd_mask=0 (e.g. store path, LD to memory) sets pend_valid but changes no flag. upd_pending still pulses.

## Test plan
- Reset -> p_out=8'h34; p_push with brk=0 = 8'h24, with brk=1 = 8'h34; carry_out=0.
- Issue ADD with mask 4'b1111; next cycle result 8'h00, carry 1, overflow 1 -> at T+2 p_out=8'hF7 & ~N: Z=1, C=1, V=1, N=0, giving 8'h77.
- Issue SHL, operand 8'h81, mask {N,Z,C}; result 8'h02, alu_carry 0 -> C=1, N=0, Z=0; carry_out=1 already during T+1.
- SEC at edge k, then ADD issued at k+1 -> carry_out=1 at k+1. Back-to-back ADD/ADD: the second op sees the first's forwarded carry.
- Same edge: p_load with p_in=8'h00, pending commit with Z=1, and SEI -> p_load wins; p_out=8'h30.
- Assert reset during T+1 of a pending ADD -> no flag change after release; p_out=8'h34; upd_pending=0.
